// File: rtl/sha_bool_pkg.sv
// sha_bool_pkg: constants shared by the SHA-2 boolean function unit.
//   - function-select encodings (the 3-bit mode input)
//   - FSM state encodings
//   - big-Sigma rotation amounts for 32-bit (SHA-256) and 64-bit (SHA-512) words
package sha_bool_pkg;

    typedef logic [2:0] mode_t;
    typedef logic [1:0] state_t;

    localparam mode_t MODE_CH   = 3'd0;
    localparam mode_t MODE_MAJ  = 3'd1;
    localparam mode_t MODE_PAR  = 3'd2;
    localparam mode_t MODE_SIG0 = 3'd3;
    localparam mode_t MODE_SIG1 = 3'd4;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WAIT  = 2'd1;
    localparam state_t ST_PROC  = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    localparam int unsigned ROT32_S0_A = 32'd2;
    localparam int unsigned ROT32_S0_B = 32'd13;
    localparam int unsigned ROT32_S0_C = 32'd22;
    localparam int unsigned ROT32_S1_A = 32'd6;
    localparam int unsigned ROT32_S1_B = 32'd11;
    localparam int unsigned ROT32_S1_C = 32'd25;

    localparam int unsigned ROT64_S0_A = 32'd28;
    localparam int unsigned ROT64_S0_B = 32'd34;
    localparam int unsigned ROT64_S0_C = 32'd39;
    localparam int unsigned ROT64_S1_A = 32'd14;
    localparam int unsigned ROT64_S1_B = 32'd18;
    localparam int unsigned ROT64_S1_C = 32'd41;

endpackage

// File: rtl/sha_bool_pipe.sv
// sha_bool_pipe: LATENCY-deep result pipeline with per-stage valid bits.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   valid_i        a new result enters stage 0 this cycle
//   data_i         result word entering stage 0
//   data_o         last stage data (holds its value across invalid cycles)
//   valid_o        last stage valid
//   any_valid_o    OR of all stage valid bits (pipeline not empty)
module sha_bool_pipe #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              any_valid_o
);

    logic [LATENCY-1:0] valid_q;
    logic [DATA_W-1:0]  data_q [LATENCY];

    // Shift stages; data only moves with a valid token so the output word is held when idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            if (valid_i) begin
                data_q[0] <= data_i;
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign data_o      = data_q[LATENCY-1];
    assign valid_o     = valid_q[LATENCY-1];
    assign any_valid_o = |valid_q;

endmodule

// File: rtl/sha_bool_fu.sv
// sha_bool_fu: pipelined SHA-2 boolean function unit (CH / MAJ / PARITY, optional big-Sigma).
// A run pulse in IDLE latches mode/delay/len, waits `delay` cycles, samples in0..in2 for
// `len` consecutive cycles and streams results out of a LATENCY-stage pipeline.
// Optional feature macro: SHA_BOOL_FU_SIGMA_EN enables modes 3 (SIG0) and 4 (SIG1) on in0.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   run                  start pulse (only honoured in IDLE)
//   mode, delay, len     transfer configuration, sampled on run
//   in0, in1, in2        operand words
//   out0, out_valid      registered result and its valid flag
//   running, done        registered status (not IDLE / IDLE)
module sha_bool_fu
    import sha_bool_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2,
    parameter int DELAY_W = 8,
    parameter int LEN_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [2:0]         mode,
    input  logic [DELAY_W-1:0] delay,
    input  logic [LEN_W-1:0]   len,
    input  logic [DATA_W-1:0]  in0,
    input  logic [DATA_W-1:0]  in1,
    input  logic [DATA_W-1:0]  in2,
    output logic [DATA_W-1:0]  out0,
    output logic               out_valid,
    output logic               running,
    output logic               done
);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("sha_bool_fu: LATENCY must be in 1..4");
    end

`ifdef SHA_BOOL_FU_SIGMA_EN
    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
        $error("sha_bool_fu: DATA_W must be 32 or 64 with Sigma enabled");
    end

    localparam int unsigned S0_A = (DATA_W == 64) ? ROT64_S0_A : ROT32_S0_A;
    localparam int unsigned S0_B = (DATA_W == 64) ? ROT64_S0_B : ROT32_S0_B;
    localparam int unsigned S0_C = (DATA_W == 64) ? ROT64_S0_C : ROT32_S0_C;
    localparam int unsigned S1_A = (DATA_W == 64) ? ROT64_S1_A : ROT32_S1_A;
    localparam int unsigned S1_B = (DATA_W == 64) ? ROT64_S1_B : ROT32_S1_B;
    localparam int unsigned S1_C = (DATA_W == 64) ? ROT64_S1_C : ROT32_S1_C;

    // Rotate right; amounts are always in 1..DATA_W-1, so both shifts are meaningful.
    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (DATA_W - n));
    endfunction
`endif

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [DELAY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [LEN_W-1:0]   item_cnt_q, item_cnt_d;
    logic               running_q, done_q;
    logic               push_s;
    logic [DATA_W-1:0]  fn_s;
    logic               pipe_busy_s;

    // Next-state and counter logic of the transfer FSM.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        dly_cnt_d  = dly_cnt_q;
        item_cnt_d = item_cnt_q;
        push_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    mode_d     = mode;
                    len_d      = len;
                    dly_cnt_d  = delay;
                    item_cnt_d = '0;
                    if (delay == '0) begin
                        if (len == '0) begin
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = ST_PROC;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Down-counter loaded with delay; the cycle showing 1 is the last wait cycle.
                if (dly_cnt_q == DELAY_W'(1)) begin
                    dly_cnt_d = '0;
                    if (len_q == '0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_PROC;
                    end
                end else begin
                    dly_cnt_d = dly_cnt_q - DELAY_W'(1);
                end
            end
            ST_PROC: begin
                push_s     = 1'b1;
                item_cnt_d = item_cnt_q + LEN_W'(1);
                // len_q >= 1 here, so len_q-1 cannot underflow.
                if (item_cnt_q == len_q - LEN_W'(1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_PROC;
                end
            end
            ST_DRAIN: begin
                if (!pipe_busy_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Boolean function of the latched mode on the current operands.
    always_comb begin
        fn_s = '0;
        case (mode_q)
            MODE_CH:  fn_s = (in0 & in1) ^ (~in0 & in2);
            MODE_MAJ: fn_s = (in0 & in1) ^ (in0 & in2) ^ (in1 & in2);
            MODE_PAR: fn_s = in0 ^ in1 ^ in2;
`ifdef SHA_BOOL_FU_SIGMA_EN
            MODE_SIG0: fn_s = rotr(in0, S0_A) ^ rotr(in0, S0_B) ^ rotr(in0, S0_C);
            MODE_SIG1: fn_s = rotr(in0, S1_A) ^ rotr(in0, S1_B) ^ rotr(in0, S1_C);
`endif
            default:  fn_s = '0;
        endcase
    end

    // FSM, configuration and status registers; status follows the next state so it is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_CH;
            len_q      <= '0;
            dly_cnt_q  <= '0;
            item_cnt_q <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            dly_cnt_q  <= dly_cnt_d;
            item_cnt_q <= item_cnt_d;
            running_q  <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_IDLE);
        end
    end

    sha_bool_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (push_s),
        .data_i      (fn_s),
        .data_o      (out0),
        .valid_o     (out_valid),
        .any_valid_o (pipe_busy_s)
    );

    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sha_bool_fu.sv
module tb_sha_bool_fu;
    import sha_bool_pkg::*;

    localparam int DW    = 32;
    localparam int LAT   = 2;
    localparam int DLY_W = 8;
    localparam int LEN_W = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic [2:0]       mode;
    logic [DLY_W-1:0] delay;
    logic [LEN_W-1:0] len;
    logic [DW-1:0]    in0, in1, in2;
    logic [DW-1:0]    out0;
    logic             out_valid, running, done;

    sha_bool_fu #(.DATA_W(DW), .LATENCY(LAT), .DELAY_W(DLY_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .run(run), .mode(mode), .delay(delay), .len(len),
        .in0(in0), .in1(in1), .in2(in2),
        .out0(out0), .out_valid(out_valid), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: per-bit truth rules and rotation by concatenation.
    function automatic logic [DW-1:0] rotr_m(input logic [DW-1:0] x, input int n);
        logic [2*DW-1:0] t;
        t = {x, x} >> n;
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] ref_fn(input logic [2:0] m, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b, input logic [DW-1:0] c);
        logic [DW-1:0] r;
        int s;
        r = '0;
        for (int i = 0; i < DW; i++) begin
            s = int'(a[i]) + int'(b[i]) + int'(c[i]);
            case (m)
                3'd0:    r[i] = a[i] ? b[i] : c[i];
                3'd1:    r[i] = (s >= 2);
                3'd2:    r[i] = (s % 2 == 1);
                default: r[i] = 1'b0;
            endcase
        end
`ifdef SHA_BOOL_FU_SIGMA_EN
        if (m == 3'd3) r = rotr_m(a, 2) ^ rotr_m(a, 13) ^ rotr_m(a, 22);
        if (m == 3'd4) r = rotr_m(a, 6) ^ rotr_m(a, 11) ^ rotr_m(a, 25);
`endif
        return r;
    endfunction

    // Monitor: every valid output must match the oldest expected item, in the expected cycle.
    always @(negedge clk) begin
        if (mon_en && !rst && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 64'(out0), 64'hDEAD_0000_0000);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out0_data", 64'(out0), 64'(e.data));
                chk("out0_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // kind: 0 random operands, 1 fixed operands, 2 incrementing operands.
    task automatic drive_ops(input int kind, input int idx, input logic [DW-1:0] a0,
                             input logic [DW-1:0] b0, input logic [DW-1:0] c0);
        case (kind)
            1: begin in0 = a0; in1 = b0; in2 = c0; end
            2: begin in0 = DW'(idx); in1 = DW'(idx * 3 + 1); in2 = DW'(idx * 7 + 2); end
            default: begin in0 = $urandom; in1 = $urandom; in2 = $urandom; end
        endcase
    endtask

    task automatic xfer(input logic [2:0] m, input int d, input int n, input int kind,
                        input logic [DW-1:0] a0, input logic [DW-1:0] b0, input logic [DW-1:0] c0,
                        input logic use_exp, input logic [DW-1:0] exp_val);
        int   r;
        logic fin;
        int   kdone;
        exp_t e;
        fin = 1'b0;
        kdone = 0;
        @(posedge clk); #1;
        r = cyc;
        run = 1'b1; mode = m; delay = DLY_W'(d); len = LEN_W'(n);
        drive_ops(kind, 0, a0, b0, c0);
        for (int k = 1; k <= d + n + LAT + 20; k++) begin
            @(posedge clk); #1;
            run = 1'b0;
            mode = 3'($urandom); delay = DLY_W'($urandom); len = LEN_W'($urandom);
            drive_ops(kind, k - 1 - d, a0, b0, c0);
            if (k == 1) chk("status_after_run", {62'd0, running, done}, 64'd2);
            if (n > 2 && k == d + 1 + n / 2) run = 1'b1;
            if (k > d && k <= d + n) begin
                e.data = use_exp ? exp_val : ref_fn(m, in0, in1, in2);
                e.cyc  = r + k + LAT;
                q.push_back(e);
            end
            if (k > d + n && done) begin
                fin = 1'b1;
                kdone = k;
                break;
            end
        end
        chk("xfer_done", 64'(fin), 64'd1);
        chk("queue_empty", 64'(q.size()), 64'd0);
        if (n == 0) chk("len0_done_cycle", 64'(kdone), 64'(d + 2));
        q.delete();
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; mode = '0; delay = '0; len = '0;
        in0 = '0; in1 = '0; in2 = '0;
        #12;
        chk("rst_out0", 64'(out0), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_done", 64'(done), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        xfer(MODE_CH, 0, 1, 1, 32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h1234DEF0);
        xfer(MODE_MAJ, 0, 1, 1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0F0F0F, 1'b1, 32'hFF00FF00);
        xfer(MODE_PAR, 0, 1, 1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0F0F0F, 1'b1, 32'h00FF00FF);
        xfer(MODE_CH, 3, 8, 2, '0, '0, '0, 1'b0, '0);
`ifdef SHA_BOOL_FU_SIGMA_EN
        xfer(MODE_SIG0, 0, 1, 1, 32'h00000001, 32'hFFFFFFFF, 32'h12345678, 1'b1, 32'h40080400);
`else
        xfer(MODE_SIG0, 0, 1, 1, 32'h00000001, 32'hFFFFFFFF, 32'h12345678, 1'b1, 32'h00000000);
`endif
        xfer(3'd6, 1, 3, 0, '0, '0, '0, 1'b1, 32'h00000000);
        xfer(MODE_MAJ, 0, 0, 0, '0, '0, '0, 1'b0, '0);
        xfer(MODE_PAR, 4, 0, 0, '0, '0, '0, 1'b0, '0);

        // Reset in the middle of a stream with items in flight.
        mon_en = 1'b0;
        @(posedge clk); #1;
        run = 1'b1; mode = MODE_PAR; delay = '0; len = LEN_W'(8);
        drive_ops(0, 0, '0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            run = 1'b0;
            drive_ops(0, 0, '0, '0, '0);
        end
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out0", 64'(out0), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd1);
        chk("mid_rst_running", 64'(running), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        mon_en = 1'b1;
        xfer(MODE_CH, 2, 5, 0, '0, '0, '0, 1'b0, '0);

        for (int t = 0; t < 12; t++) begin
            xfer(3'($urandom_range(0, 7)), int'($urandom_range(0, 5)), int'($urandom_range(0, 12)),
                 0, '0, '0, '0, 1'b0, '0);
        end
        // Maximum delay and length.
        xfer(MODE_MAJ, (1 << DLY_W) - 1, (1 << LEN_W) - 1, 0, '0, '0, '0, 1'b0, '0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
